// File: rtl/spsram_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous SRAM (1-cycle read latency).
// Round-robin or fixed-priority grant, bounded read-modify-write lock, read return at T+1.
module spsram_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int FIXED_PRIORITY = 0,
  parameter int LOCK_MAX       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_we,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  logic                  r_rr_last;
  logic                  r_lock_act;
  logic                  r_lock_owner;
  logic [3:0]            r_lock_cnt;
  logic                  r_prio_act;
  logic                  r_prio_port;
  logic                  r_sel;
  logic                  r_rd_pending;
  logic                  r_rd_port;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic       w_lock_hit;
  logic       w_gnt;
  logic       w_gport;
  logic       w_gnt_q;
  logic       w_sel;
  logic       w_we;
  logic       w_lk;
  logic [3:0] w_cnt_inc;

  // A lock only binds while its owner keeps requesting; an idle owner frees the port this cycle.
  assign w_lock_hit = r_lock_act && (r_lock_owner ? req1 : req0);

  always_comb begin
    w_gnt   = 1'b0;
    w_gport = 1'b0;
    if (w_lock_hit) begin
      w_gnt   = 1'b1;
      w_gport = r_lock_owner;
    end else if (req0 && req1) begin
      w_gnt = 1'b1;
      if (r_prio_act)
        w_gport = r_prio_port;
      else if (FIXED_PRIORITY != 0)
        w_gport = 1'b0;
      else
        w_gport = ~r_rr_last;
    end else if (req0) begin
      w_gnt   = 1'b1;
      w_gport = 1'b0;
    end else if (req1) begin
      w_gnt   = 1'b1;
      w_gport = 1'b1;
    end
  end

  assign w_gnt_q   = w_gnt & reset_n;
  assign w_we      = w_gport ? we1 : we0;
  assign w_lk      = w_gport ? lock1 : lock0;
  assign w_cnt_inc = r_lock_cnt + 4'd1;

  // With no request the address/data mux keeps pointing at the last granted port.
  assign w_sel      = w_gnt ? w_gport : r_sel;
  assign sram_addr  = w_sel ? addr1 : addr0;
  assign sram_wdata = w_sel ? wdata1 : wdata0;
  assign sram_we    = w_gnt_q & w_we;

  assign ack0 = w_gnt_q & ~w_gport;
  assign ack1 = w_gnt_q & w_gport;

  assign rvalid0 = r_rd_pending & ~r_rd_port;
  assign rvalid1 = r_rd_pending & r_rd_port;
  assign rdata0  = rvalid0 ? sram_q : r_rdata0;
  assign rdata1  = rvalid1 ? sram_q : r_rdata1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_last    <= 1'b1;
      r_lock_act   <= 1'b0;
      r_lock_owner <= 1'b0;
      r_lock_cnt   <= 4'd0;
      r_prio_act   <= 1'b0;
      r_prio_port  <= 1'b0;
      r_sel        <= 1'b0;
      r_rd_pending <= 1'b0;
      r_rd_port    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_prio_act   <= 1'b0;
      r_rd_pending <= w_gnt && !w_we;
      if (w_gnt) begin
        r_rr_last <= w_gport;
        r_sel     <= w_gport;
        r_rd_port <= w_gport;
      end
      if (r_rd_pending) begin
        if (r_rd_port)
          r_rdata1 <= sram_q;
        else
          r_rdata0 <= sram_q;
      end

      if (w_lock_hit) begin
        if (!w_lk || (w_cnt_inc >= LOCK_MAX_C)) begin
          r_lock_act <= 1'b0;
          r_lock_cnt <= 4'd0;
          if (w_lk) begin
            // Lock ran out: hand the next tie to the other port.
            r_prio_act  <= 1'b1;
            r_prio_port <= ~r_lock_owner;
          end
        end else begin
          r_lock_cnt <= w_cnt_inc;
        end
      end else if (w_gnt && w_lk) begin
        if (LOCK_MAX_C <= 4'd1) begin
          r_lock_act  <= 1'b0;
          r_lock_cnt  <= 4'd0;
          r_prio_act  <= 1'b1;
          r_prio_port <= ~w_gport;
        end else begin
          r_lock_act   <= 1'b1;
          r_lock_owner <= w_gport;
          r_lock_cnt   <= 4'd1;
        end
      end else begin
        r_lock_act <= 1'b0;
        r_lock_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_spsram_arbiter.sv
// Bench for spsram_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own SRAM model; read data expectations flow through a queue.
module tb_spsram_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          a_ack0, a_rvalid0, a_ack1, a_rvalid1, a_sram_we;
  logic [DW-1:0] a_rdata0, a_rdata1, a_sram_wdata, a_q;
  logic [AW-1:0] a_sram_addr;
  logic          b_ack0, b_rvalid0, b_ack1, b_rvalid1, b_sram_we;
  logic [DW-1:0] b_rdata0, b_rdata1, b_sram_wdata, b_q;
  logic [AW-1:0] b_sram_addr;

  spsram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0), .LOCK_MAX(4)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .ack0(a_ack0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .ack1(a_ack1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
    .sram_addr(a_sram_addr), .sram_we(a_sram_we), .sram_wdata(a_sram_wdata), .sram_q(a_q)
  );

  spsram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1), .LOCK_MAX(4)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .ack0(b_ack0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .ack1(b_ack1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .sram_addr(b_sram_addr), .sram_we(b_sram_we), .sram_wdata(b_sram_wdata), .sram_q(b_q)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      12'h001: return 16'hA001;
      12'h002: return 16'hB002;
      12'h010: return 16'h1234;
      12'h020: return 16'h5555;
      default: return {4'h0, a} ^ 16'h0F0F;
    endcase
  endfunction

  // SRAM models: write-through q, unwritten words return their preload value.
  logic [DW-1:0] mem_a [0:4095];
  bit            wr_a  [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  bit            wr_b  [0:4095];

  always @(posedge clk) begin
    if (a_sram_we) begin
      mem_a[a_sram_addr] <= a_sram_wdata;
      wr_a[a_sram_addr]  <= 1'b1;
      a_q                <= a_sram_wdata;
    end else begin
      a_q <= wr_a[a_sram_addr] ? mem_a[a_sram_addr] : init_val(a_sram_addr);
    end
  end

  always @(posedge clk) begin
    if (b_sram_we) begin
      mem_b[b_sram_addr] <= b_sram_wdata;
      wr_b[b_sram_addr]  <= 1'b1;
      b_q                <= b_sram_wdata;
    end else begin
      b_q <= wr_b[b_sram_addr] ? mem_b[b_sram_addr] : init_val(b_sram_addr);
    end
  end

  bit use_fp = 1'b0;
  logic          s_ack0, s_ack1, s_rvalid0, s_rvalid1, s_sram_we;
  logic [DW-1:0] s_rdata0, s_rdata1, s_sram_wdata;
  logic [AW-1:0] s_sram_addr;
  assign s_ack0       = use_fp ? b_ack0       : a_ack0;
  assign s_ack1       = use_fp ? b_ack1       : a_ack1;
  assign s_rvalid0    = use_fp ? b_rvalid0    : a_rvalid0;
  assign s_rvalid1    = use_fp ? b_rvalid1    : a_rvalid1;
  assign s_rdata0     = use_fp ? b_rdata0     : a_rdata0;
  assign s_rdata1     = use_fp ? b_rdata1     : a_rdata1;
  assign s_sram_we    = use_fp ? b_sram_we    : a_sram_we;
  assign s_sram_addr  = use_fp ? b_sram_addr  : a_sram_addr;
  assign s_sram_wdata = use_fp ? b_sram_wdata : a_sram_wdata;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
  } rd_t;
  rd_t           exp_q[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic drive(input bit r0, input bit w0, input bit l0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit r1, input bit w1, input bit l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic step_check(input bit e0, input bit e1);
    rd_t ent;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      chk("rvalid_hit",   ent.port ? s_rvalid1 : s_rvalid0, 1);
      chk("rvalid_other", ent.port ? s_rvalid0 : s_rvalid1, 0);
      chk("rdata",        ent.port ? s_rdata1  : s_rdata0,  ent.data);
    end else begin
      chk("rvalid0_idle", s_rvalid0, 0);
      chk("rvalid1_idle", s_rvalid1, 0);
    end
    chk("ack0", s_ack0, e0);
    chk("ack1", s_ack1, e1);
    if (e0) begin
      chk("sram_addr0", s_sram_addr, addr0);
      chk("sram_we0", s_sram_we, we0);
      if (we0) begin
        chk("sram_wdata0", s_sram_wdata, wdata0);
        shadow[addr0] = wdata0;
      end else exp_q.push_back('{port: 1'b0, data: exp_rd(addr0)});
      $display("[%0t] %s port0 %s addr=%03h", $time, use_fp ? "fp" : "rr", we0 ? "wr" : "rd", addr0);
    end
    if (e1) begin
      chk("sram_addr1", s_sram_addr, addr1);
      chk("sram_we1", s_sram_we, we1);
      if (we1) begin
        chk("sram_wdata1", s_sram_wdata, wdata1);
        shadow[addr1] = wdata1;
      end else exp_q.push_back('{port: 1'b1, data: exp_rd(addr1)});
      $display("[%0t] %s port1 %s addr=%03h", $time, use_fp ? "fp" : "rr", we1 ? "wr" : "rd", addr1);
    end
    if (!e0 && !e1) chk("sram_we_idle", s_sram_we, 0);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit e0, input bit e1);
    step_check(e0, e1);
    advance();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a request pending to prove ack/sram_we are gated
    drive(1, 1, 0, 12'h010, 16'hDEAD, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rst_ack0", s_ack0, 0);
    chk("rst_sram_we", s_sram_we, 0);
    chk("rst_rvalid0", s_rvalid0, 0);
    chk("rst_rdata0", s_rdata0, 0);
    chk("rst_rdata1", s_rdata1, 0);
    do_reset();

    // Single read on port 0
    drive(1, 0, 0, 12'h010, '0, 0, 0, 0, '0, '0);
    cyc(1, 0);
    drive_idle();
    cyc(0, 0);

    // Round-robin alternation
    do_reset();
    drive(1, 0, 0, 12'h001, '0, 1, 0, 0, 12'h002, '0);
    cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(0, 1);
    drive_idle();
    cyc(0, 0);

    // Same-address read (port 0) and write (port 1)
    drive(1, 0, 0, 12'h020, '0, 1, 1, 0, 12'h020, 16'h00AA);
    cyc(1, 0);
    drive(0, 0, 0, '0, '0, 1, 1, 0, 12'h020, 16'h00AA);
    cyc(0, 1);
    drive(1, 0, 0, 12'h020, '0, 0, 0, 0, '0, '0);
    cyc(1, 0);
    drive_idle();
    cyc(0, 0);

    // Idle lock owner releases immediately
    drive(1, 0, 1, 12'h001, '0, 0, 0, 0, '0, '0);
    cyc(1, 0);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 12'h002, '0);
    cyc(0, 1);
    drive_idle();
    cyc(0, 0);

    // Bounded lock, round-robin
    do_reset();
    drive(1, 0, 1, 12'h001, '0, 1, 0, 0, 12'h002, '0);
    repeat (4) cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    drive_idle();
    cyc(0, 0);

    // Fixed priority instance
    use_fp = 1'b1;
    do_reset();
    drive(1, 0, 0, 12'h001, '0, 1, 0, 0, 12'h002, '0);
    repeat (4) cyc(1, 0);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 12'h002, '0);
    cyc(0, 1);
    drive_idle();
    cyc(0, 0);
    drive(1, 0, 1, 12'h001, '0, 1, 0, 0, 12'h002, '0);
    repeat (4) cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    drive_idle();
    cyc(0, 0);

    // Reset in the middle of a read
    use_fp = 1'b0;
    do_reset();
    drive(0, 0, 0, '0, '0, 1, 0, 0, 12'h002, '0);
    cyc(0, 1);
    drive(1, 0, 0, 12'h010, '0, 0, 0, 0, '0, '0);
    cyc(1, 0);
    drive_idle();
    cyc(0, 0);
    drive(1, 0, 1, 12'h010, '0, 0, 0, 0, '0, '0);
    step_check(1, 0);
    #2 reset_n = 1'b0;
    exp_q.delete();
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1, 0, 0, 12'h001, '0, 1, 0, 0, 12'h002, '0);
    step_check(1, 0);
    chk("post_rst_rdata0", s_rdata0, 0);
    chk("post_rst_rdata1", s_rdata1, 0);
    advance();
    cyc(0, 1);
    drive_idle();
    cyc(0, 0);
    cyc(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
